// File: rtl/vga_sync_rx_if.sv
// Incoming VGA source pins: active-low HSync/VSync plus one RGB332 pixel.
// The source drives the master side; vga_sync_rx receives on the slave side.
interface vga_sync_rx_if;
  logic       HSync;
  logic       VSync;
  logic [2:0] Red;
  logic [2:0] Green;
  logic [1:0] Blue;

  modport master (output HSync, output VSync, output Red, output Green, output Blue);
  modport slave  (input  HSync, input  VSync, input  Red, input  Green, input  Blue);
endinterface

// File: rtl/vga_sync_rx.sv
// VGA receive side: recovers x/y/active from external sync, measures timing, declares lock.
// Define VGA_SYNC_RX_CAPTURE_EN to add the 32x32 one-bit window capture into a 128x8 bitmap.
module vga_sync_rx #(
  parameter int unsigned H_START  = 144,
  parameter int unsigned V_START  = 35,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned WIN_X    = 50,
  parameter int unsigned WIN_Y    = 60
) (
  input  logic                CLK,
  input  logic                RST,
  vga_sync_rx_if.slave        vga,
  output logic [9:0]          x,
  output logic [9:0]          y,
  output logic                active,
  output logic [9:0]          line_len,
  output logic [9:0]          frame_lines,
  output logic                locked,
  output logic                cap_done,
  input  logic [6:0]          rd_addr,
  output logic [7:0]          rd_data
);

  localparam logic [10:0] H_LO    = 11'(H_START);
  localparam logic [10:0] H_HI    = 11'(H_START + H_ACTIVE);
  localparam logic [10:0] V_LO    = 11'(V_START);
  localparam logic [10:0] V_HI    = 11'(V_START + V_ACTIVE);
  localparam logic [9:0]  H_OFF   = 10'(H_START);
  localparam logic [9:0]  V_OFF   = 10'(V_START);
  localparam logic [9:0]  MIN_LEN = 10'd64;

  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

  state_t      state_q, state_d;
  logic [2:0]  hs_q, hs_d;
  logic [2:0]  vs_q, vs_d;
  logic        hs_fall, vs_fall;
  logic [9:0]  hcnt_q, hcnt_d;
  logic [9:0]  vcnt_q, vcnt_d;
  logic [9:0]  line_len_q, line_len_d;
  logic [9:0]  frame_lines_q, frame_lines_d;
  logic [9:0]  x_q, x_d, y_q, y_d;
  logic        active_q, active_d;
  logic [9:0]  x_c, y_c;
  logic        active_c;
  logic [9:0]  new_len, new_lines;
  logic [9:0]  ref_len_q, ref_len_d;
  logic [9:0]  ref_lines_q, ref_lines_d;
  logic [9:0]  cand_q, cand_d;
  logic        seen_q, seen_d;
  logic        ok_q, ok_d;
  logic [9:0]  fold_cand;
  logic        fold_seen, fold_ok;

  // Sync chain, counters and registered coordinate outputs
  always_comb begin
    hs_d          = {hs_q[1:0], vga.HSync};
    vs_d          = {vs_q[1:0], vga.VSync};
    hs_fall       = hs_q[2] & ~hs_q[1];
    vs_fall       = vs_q[2] & ~vs_q[1];
    new_len       = hcnt_q + 10'd1;
    new_lines     = vcnt_q + 10'd1;
    hcnt_d        = hcnt_q;
    vcnt_d        = vcnt_q;
    line_len_d    = line_len_q;
    frame_lines_d = frame_lines_q;

    if (hs_fall)             hcnt_d = '0;
    else if (hcnt_q != '1)   hcnt_d = hcnt_q + 10'd1;

    if (vs_fall)             vcnt_d = '0;
    else if (hs_fall)        vcnt_d = vcnt_q + 10'd1;

    if (hs_fall) line_len_d    = new_len;
    if (vs_fall) frame_lines_d = new_lines;

    x_c      = hcnt_q - H_OFF;
    y_c      = vcnt_q - V_OFF;
    active_c = (state_q == LOCKED) &&
               ({1'b0, hcnt_q} >= H_LO) && ({1'b0, hcnt_q} < H_HI) &&
               ({1'b0, vcnt_q} >= V_LO) && ({1'b0, vcnt_q} < V_HI);
    x_d      = x_c;
    y_d      = y_c;
    active_d = active_c;
  end

  // Lock FSM
  always_comb begin
    state_d     = state_q;
    ref_len_d   = ref_len_q;
    ref_lines_d = ref_lines_q;
    cand_d      = cand_q;
    seen_d      = seen_q;
    ok_d        = ok_q;
    fold_cand   = cand_q;
    fold_seen   = seen_q;
    fold_ok     = ok_q;

    // A line closing on the same cycle as VSync still belongs to the frame being judged
    if (hs_fall) begin
      if (!seen_q) begin
        fold_seen = 1'b1;
        fold_cand = new_len;
        fold_ok   = (new_len >= MIN_LEN);
      end else begin
        fold_ok   = ok_q && (new_len == cand_q);
      end
    end

    unique case (state_q)
      SEARCH: begin
        if (vs_fall) begin
          state_d = MEASURE;
          seen_d  = 1'b0;
          ok_d    = 1'b1;
        end
      end
      MEASURE: begin
        seen_d = fold_seen;
        ok_d   = fold_ok;
        cand_d = fold_cand;
        if (vs_fall) begin
          if (fold_seen && fold_ok) begin
            state_d     = LOCKED;
            ref_len_d   = fold_cand;
            ref_lines_d = new_lines;
          end
          seen_d = 1'b0;
          ok_d   = 1'b1;
        end
      end
      LOCKED: begin
        if ((hs_fall && (new_len != ref_len_q)) ||
            (vs_fall && (new_lines != ref_lines_q)) ||
            (hcnt_d == '1))
          state_d = SEARCH;
      end
      default: state_d = SEARCH;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q       <= SEARCH;
      hs_q          <= '1;
      vs_q          <= '1;
      hcnt_q        <= '0;
      vcnt_q        <= '0;
      line_len_q    <= '0;
      frame_lines_q <= '0;
      x_q           <= '0;
      y_q           <= '0;
      active_q      <= 1'b0;
      ref_len_q     <= '0;
      ref_lines_q   <= '0;
      cand_q        <= '0;
      seen_q        <= 1'b0;
      ok_q          <= 1'b0;
    end else begin
      state_q       <= state_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      hcnt_q        <= hcnt_d;
      vcnt_q        <= vcnt_d;
      line_len_q    <= line_len_d;
      frame_lines_q <= frame_lines_d;
      x_q           <= x_d;
      y_q           <= y_d;
      active_q      <= active_d;
      ref_len_q     <= ref_len_d;
      ref_lines_q   <= ref_lines_d;
      cand_q        <= cand_d;
      seen_q        <= seen_d;
      ok_q          <= ok_d;
    end
  end

  assign x           = x_q;
  assign y           = y_q;
  assign active      = active_q;
  assign line_len    = line_len_q;
  assign frame_lines = frame_lines_q;
  assign locked      = (state_q == LOCKED);

`ifdef VGA_SYNC_RX_CAPTURE_EN
  logic [2:0][7:0] rgb_q, rgb_d;
  logic [7:0]      shreg_q, shreg_d;
  logic            cap_done_q, cap_done_d;
  logic [7:0]      rd_data_q, rd_data_d;
  logic [7:0]      mem [128];
  logic [9:0]      xw, yw;
  logic            in_win, g_bit, we;
  logic [6:0]      waddr;
  logic [7:0]      wdata;
  logic            unused_rgb;

  // RGB rides three stages so stage 3 lines up with hcnt/vcnt
  always_comb begin
    rgb_d      = {rgb_q[1:0], vga.Red, vga.Green, vga.Blue};
    g_bit      = |rgb_q[2][4:2];
    xw         = x_c - 10'(WIN_X);
    yw         = y_c - 10'(WIN_Y);
    in_win     = active_c && (xw < 10'd32) && (yw < 10'd32);
    shreg_d    = in_win ? {shreg_q[6:0], g_bit} : shreg_q;
    wdata      = {shreg_q[6:0], g_bit};
    waddr      = {yw[4:0], xw[4:3]};
    we         = in_win && (xw[2:0] == 3'd7);
    cap_done_d = we && (waddr == 7'd127);
    rd_data_d  = mem[rd_addr];
  end

  assign unused_rgb = ^{rgb_q[2][7:5], rgb_q[2][1:0]};

  always_ff @(posedge CLK) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rgb_q      <= '0;
      shreg_q    <= '0;
      cap_done_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rgb_q      <= rgb_d;
      shreg_q    <= shreg_d;
      cap_done_q <= cap_done_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign cap_done = cap_done_q;
  assign rd_data  = rd_data_q;
`else
  logic unused_cap;

  assign unused_cap = ^{rd_addr, vga.Red, vga.Green, vga.Blue, 10'(WIN_X), 10'(WIN_Y)};
  assign cap_done   = 1'b0;
  assign rd_data    = '0;
`endif

endmodule

// File: tb/tb_vga_sync_rx.sv
// Directed bench for vga_sync_rx using a shrunken 80x50 timing so several frames fit in a short run.
module tb_vga_sync_rx;
  localparam int HS = 20, HA = 40, VS = 3, VA = 40, WX = 4, WY = 2;
  localparam int LLEN = 80, NL = 50, HSW = 8;
`ifdef VGA_SYNC_RX_CAPTURE_EN
  localparam int CAP = 1;
`else
  localparam int CAP = 0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] x, y, line_len, frame_lines;
  logic       active, locked, cap_done;
  logic [6:0] rd_addr;
  logic [7:0] rd_data;

  int n_asrt = 0, n_fail = 0;
  int fr_pos = 0, l_pos = 0, k_pos = 0;
  int short_fr = -1, short_l = -1;
  int cap_cnt = 0;

  always #5 clk = ~clk;

  vga_sync_rx_if vif ();

  vga_sync_rx #(
    .H_START (HS), .V_START (VS), .H_ACTIVE (HA), .V_ACTIVE (VA),
    .WIN_X (WX), .WIN_Y (WY)
  ) dut (
    .CLK (clk), .RST (rst), .vga (vif),
    .x (x), .y (y), .active (active),
    .line_len (line_len), .frame_lines (frame_lines),
    .locked (locked), .cap_done (cap_done),
    .rd_addr (rd_addr), .rd_data (rd_data)
  );

  // Source bitmap, byte i = row i/4, columns 8*(i%4)..+7, bit 7 leftmost
  function automatic logic [7:0] pat(input int i);
    return 8'((i * 29 + 7) ^ (i >> 3));
  endfunction

  function automatic logic [2:0] green_at(input int l, input int k);
    int c, r, wx, wy;
    logic [7:0] b;
    c = k - HS;
    r = l - VS;
    if (r < 0 || r >= VA || c < 0 || c >= HA) return 3'b000;
    wx = c - WX;
    wy = r - WY;
    if (wx < 0 || wx >= 32 || wy < 0 || wy >= 32) return 3'b111;
    b = pat(wy * 4 + wx / 8);
    return b[7 - (wx % 8)] ? 3'b010 : 3'b000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pix(input logic h, input logic v, input logic [2:0] g);
    vif.HSync = h;
    vif.VSync = v;
    vif.Green = g;
    vif.Red   = ~g;
    vif.Blue  = 2'b10;
    @(posedge clk);
    #1;
    if (cap_done) cap_cnt++;
  endtask

  task automatic tick();
    int len;
    len = (fr_pos == short_fr && l_pos == short_l) ? LLEN - 1 : LLEN;
    pix(k_pos >= HSW, l_pos >= 2, green_at(l_pos, k_pos));
    k_pos++;
    if (k_pos >= len) begin
      k_pos = 0;
      l_pos++;
      if (l_pos >= NL) begin
        l_pos = 0;
        fr_pos++;
      end
    end
  endtask

  task automatic run_to(input int f, input int l, input int k);
    int guard;
    guard = 0;
    while (!(fr_pos == f && l_pos == l && k_pos == k)) begin
      tick();
      guard++;
      if (guard > 20000) begin
        n_fail++;
        $display("FAIL run_to: position %0d/%0d/%0d never reached", f, l, k);
        $fatal(1, "stimulus position overrun");
      end
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_x"}, 32'(x), 0);
    chk({tag, "_y"}, 32'(y), 0);
    chk({tag, "_active"}, 32'(active), 0);
    chk({tag, "_line_len"}, 32'(line_len), 0);
    chk({tag, "_frame_lines"}, 32'(frame_lines), 0);
    chk({tag, "_locked"}, 32'(locked), 0);
    chk({tag, "_cap_done"}, 32'(cap_done), 0);
    chk({tag, "_rd_data"}, 32'(rd_data), 0);
  endtask

  initial begin
    rst = 1'b1;
    rd_addr = '0;
    vif.HSync = 1'b1;
    vif.VSync = 1'b1;
    vif.Red = '0;
    vif.Green = '0;
    vif.Blue = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    rst = 1'b0;

    // Frame 0 start enters MEASURE, frame 1 start locks
    run_to(1, 0, 2);
    chk("lock_before_2nd_vs", 32'(locked), 0);
    tick();
    chk("lock_at_2nd_vs", 32'(locked), 1);
    chk("line_len_80", 32'(line_len), 80);
    chk("frame_lines_50", 32'(frame_lines), 50);
    cap_cnt = 0;

    // Active window edges, 4 cycles after the pixel reaches the pin
    run_to(1, 3, 23);
    chk("active_before_first", 32'(active), 0);
    tick();
    chk("active_first", 32'(active), 1);
    chk("x_first", 32'(x), 0);
    chk("y_first", 32'(y), 0);
    run_to(1, 3, 63);
    chk("active_last_col", 32'(active), 1);
    chk("x_last_col", 32'(x), 39);
    tick();
    chk("active_past_col", 32'(active), 0);
    run_to(1, 42, 24);
    chk("active_last_row", 32'(active), 1);
    chk("y_last_row", 32'(y), 39);
    run_to(1, 43, 24);
    chk("active_past_row", 32'(active), 0);

    run_to(2, 0, 3);
    chk("cap_done_frame1", 32'(cap_cnt), 32'(CAP));
    chk("still_locked", 32'(locked), 1);
    cap_cnt = 0;

    // Readback in the bottom blanking, clear of this frame's capture
    run_to(2, 44, 0);
    for (int a = 0; a < 128; a++) begin
      rd_addr = 7'(a);
      tick();
      chk($sformatf("bitmap_%0d", a), 32'(rd_data), (CAP != 0) ? 32'(pat(a)) : 32'd0);
    end

    run_to(3, 0, 3);
    chk("cap_done_frame2", 32'(cap_cnt), 32'(CAP));
    cap_cnt = 0;

    // Line 10 of frame 3 is 79 cycles; lock drops on its closing HSync edge
    short_fr = 3;
    short_l = 10;
    run_to(3, 11, 2);
    chk("locked_before_short", 32'(locked), 1);
    tick();
    chk("unlock_short_line", 32'(locked), 0);
    chk("line_len_79", 32'(line_len), 79);
    run_to(5, 0, 2);
    chk("relock_not_early", 32'(locked), 0);
    tick();
    chk("relock_after_2_vs", 32'(locked), 1);
    chk("no_cap_done_aborted", 32'(cap_cnt), 0);

    // HSync stuck high: hcnt saturates and lock drops as it reaches 1023
    run_to(5, 1, 10);
    for (int i = 10; i <= 1107; i++) begin
      pix(1'b1, 1'b1, 3'b000);
      if (i == 1024) chk("hold_locked_at_1022", 32'(locked), 1);
      if (i == 1025) chk("hold_unlock_at_1023", 32'(locked), 0);
    end
    fr_pos = 6;
    l_pos = 0;
    k_pos = 0;
    run_to(6, 0, 3);
    chk("line_len_trunc_1024", 32'(line_len), 0);
    chk("frame_lines_short", 32'(frame_lines), 2);
    run_to(7, 0, 3);
    chk("relock_after_hold", 32'(locked), 1);

    // Reset in the middle of a locked frame
    run_to(7, 20, 31);
    chk("mid_active", 32'(active), 1);
    chk("mid_x", 32'(x), 7);
    chk("mid_y", 32'(y), 17);
    rst = 1'b1;
    tick();
    chk_zero("mid_reset");
    rst = 1'b0;
    run_to(9, 0, 2);
    chk("post_rst_not_early", 32'(locked), 0);
    tick();
    chk("post_rst_relock", 32'(locked), 1);
    chk("post_rst_line_len", 32'(line_len), 80);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
